// File: rtl/bdpsk_symbol_source_if.sv
// Bit-delivery port of the BDPSK symbol source.
//
// Handshake: the master offers data_in with data_valid; the slave raises
// data_ready while it can take one bit. A bit is transferred on any rising
// clk edge where data_valid && data_ready are both high. The master must keep
// data_in stable while data_valid is high and must not make data_valid depend
// combinationally on data_ready.
interface bdpsk_symbol_source_if;
    logic data_in;
    logic data_valid;
    logic data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/bdpsk_symbol_source.sv
// BDPSK symbol source: preamble of ones, then external or PRBS7 data bits,
// differentially encoded onto re. re/bit_out change only on carrier-period
// boundaries that end a symbol, so phase flips line up with sine-table wrap.
// Optional feature macro: BDPSK_PRBS_EN compiles in the PRBS7 generator and
// makes src_sel select between it (1) and the external port (0).
module bdpsk_symbol_source #(
    parameter int SAMPLES_PER_CYCLE = 128,
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int PREAMBLE_LEN      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       src_sel,
    bdpsk_symbol_source_if.slave       bit_if,
    output logic                       re,
    output logic                       bit_out,
    output logic                       sym_strobe,
    output logic                       underrun,
    output logic [1:0]                 state
);

    localparam int SW = (SAMPLES_PER_CYCLE > 1) ? $clog2(SAMPLES_PER_CYCLE) : 1;
    localparam int CW = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
    localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_CYCLE - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_SYMBOL - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t        st;
    logic [SW-1:0] samp_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [PW-1:0] pre_cnt;
    logic          buf_full;
    logic          buf_bit;
    logic          stop_req;

    logic          boundary;
    logic          accept;
    logic          stop_now;
    logic          use_prbs;
    logic          prbs_bit;
    logic          data_bit;
    logic          data_hit;

    assign state    = st;
    assign boundary = (st != ST_IDLE) && (samp_cnt == SAMP_LAST) && (cyc_cnt == CYC_LAST);
    assign sym_strobe = boundary;

    // Buffer can take a bit only while sending data and empty.
    assign bit_if.data_ready = (st == ST_DATA) && !buf_full;
    assign accept   = bit_if.data_valid && bit_if.data_ready;

    // A drop of enable at any point in the symbol is remembered until the boundary.
    assign stop_now = stop_req || !enable;

`ifdef BDPSK_PRBS_EN
    logic [6:0] lfsr;

    assign use_prbs = src_sel;
    assign prbs_bit = lfsr[6];

    // PRBS7 (x^7+x^6+1): reseed on preamble entry, step on every data-bit load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 7'h7F;
        end else if (st == ST_IDLE && enable) begin
            lfsr <= 7'h7F;
        end else if (boundary && !stop_now && use_prbs &&
                     (st == ST_DATA || pre_cnt == PRE_LAST)) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
`else
    logic unused_src_sel;

    assign use_prbs       = 1'b0;
    assign prbs_bit       = 1'b0;
    assign unused_src_sel = src_sel;
`endif

    // Pick the next data bit: PRBS, buffered bit, or a bit arriving this clock.
    always_comb begin
        data_bit = 1'b0;
        data_hit = 1'b0;
        if (use_prbs) begin
            data_bit = prbs_bit;
            data_hit = 1'b1;
        end else if (buf_full) begin
            data_bit = buf_bit;
            data_hit = 1'b1;
        end else if (accept) begin
            data_bit = bit_if.data_in;
            data_hit = 1'b1;
        end
    end

    // Main FSM: timing counters, bit buffer and registered symbol outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_IDLE;
            samp_cnt <= '0;
            cyc_cnt  <= '0;
            pre_cnt  <= '0;
            buf_full <= 1'b0;
            buf_bit  <= 1'b0;
            stop_req <= 1'b0;
            re       <= 1'b0;
            bit_out  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (st == ST_IDLE) begin
                samp_cnt <= '0;
                cyc_cnt  <= '0;
                pre_cnt  <= '0;
                buf_full <= 1'b0;
                stop_req <= 1'b0;
                if (enable) begin
                    // First preamble symbol is loaded on the entry edge.
                    st      <= ST_PREAMBLE;
                    bit_out <= 1'b1;
                    re      <= ~re;
                end
            end else begin
                if (samp_cnt == SAMP_LAST) begin
                    samp_cnt <= '0;
                    cyc_cnt  <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + 1'b1;
                end else begin
                    samp_cnt <= samp_cnt + 1'b1;
                end

                if (!enable) begin
                    stop_req <= 1'b1;
                end

                if (boundary) begin
                    if (stop_now) begin
                        // Symbol finished: park with phase held.
                        st       <= ST_IDLE;
                        bit_out  <= 1'b0;
                        buf_full <= 1'b0;
                        pre_cnt  <= '0;
                        stop_req <= 1'b0;
                    end else if (st == ST_PREAMBLE && pre_cnt != PRE_LAST) begin
                        bit_out <= 1'b1;
                        re      <= ~re;
                        pre_cnt <= pre_cnt + 1'b1;
                    end else begin
                        // Data-bit load; an empty external source sends 0 (no flip).
                        st       <= ST_DATA;
                        pre_cnt  <= '0;
                        bit_out  <= data_bit;
                        re       <= re ^ data_bit;
                        buf_full <= 1'b0;
                        if (st == ST_DATA && !data_hit) begin
                            underrun <= 1'b1;
                        end
                    end
                end else if (accept) begin
                    buf_full <= 1'b1;
                    buf_bit  <= bit_if.data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_bdpsk_symbol_source.sv
// Directed bench for bdpsk_symbol_source at default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_bdpsk_symbol_source;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       src_sel;
    logic       re;
    logic       bit_out;
    logic       sym_strobe;
    logic       underrun;
    logic [1:0] state;

    int errors;
    int checks;
    logic r_exp;

    bdpsk_symbol_source_if bit_if();

    bdpsk_symbol_source dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .src_sel    (src_sel),
        .bit_if     (bit_if),
        .re         (re),
        .bit_out    (bit_out),
        .sym_strobe (sym_strobe),
        .underrun   (underrun),
        .state      (state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL rst_re: got %0b want 0", re); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL rst_bit_out: got %0b want 0", bit_out); end
        checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %0b want 0", sym_strobe); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (bit_if.data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", bit_if.data_ready); end
        // Start a preamble, then reset it at samp_cnt = 37
        reset = 1'b0;
        enable = 1'b1;
        step(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_entry_state: got %0d want 1", state); end
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL rst_entry_re: got %0b want 1", re); end
        step(37);
        #2 reset = 1'b1;
        #1;
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL mid_rst_re: got %0b want 0", re); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL mid_rst_bit_out: got %0b want 0", bit_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", state); end
        checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe: got %0b want 0", sym_strobe); end
        step(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_hold_state: got %0d want 0", state); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL mid_rst_hold_re: got %0b want 0", re); end
        reset = 1'b0;
    endtask

    task automatic test_preamble;
        logic exp_re;
        exp_re = 1'b1;
        step(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_state: got %0d want 1", state); end
        checks++; if (bit_if.data_ready !== 1'b0) begin errors++; $display("FAIL pre_ready: got %0b want 0", bit_if.data_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (re !== exp_re) begin errors++; $display("FAIL pre_re sym%0d: got %0b want %0b", k, re, exp_re); end
            checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL pre_bit sym%0d: got %0b want 1", k, bit_out); end
            checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL pre_strobe_first sym%0d: got %0b want 0", k, sym_strobe); end
            step(511);
            checks++; if (sym_strobe !== 1'b1) begin errors++; $display("FAIL pre_strobe_last sym%0d: got %0b want 1", k, sym_strobe); end
            checks++; if (re !== exp_re) begin errors++; $display("FAIL pre_re_hold sym%0d: got %0b want %0b", k, re, exp_re); end
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_state_last sym%0d: got %0d want 1", k, state); end
            step(1);
            exp_re = ~exp_re;
        end
        // 4096 clocks after entry: first data symbol, empty buffer sends 0
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_end_state: got %0d want 2", state); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL pre_end_re: got %0b want 0", re); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL pre_end_bit: got %0b want 0", bit_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL pre_end_underrun: got %0b want 0", underrun); end
        checks++; if (bit_if.data_ready !== 1'b1) begin errors++; $display("FAIL pre_end_ready: got %0b want 1", bit_if.data_ready); end
    endtask

    task automatic test_external;
        logic [3:0] bits;
        logic       b;
        bits = 4'b1011;
        r_exp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = bits[3-i];
            checks++; if (bit_if.data_ready !== 1'b1) begin errors++; $display("FAIL ext_ready bit%0d: got %0b want 1", i, bit_if.data_ready); end
            bit_if.data_in = b;
            bit_if.data_valid = 1'b1;
            step(1);
            bit_if.data_valid = 1'b0;
            checks++; if (bit_if.data_ready !== 1'b0) begin errors++; $display("FAIL ext_full bit%0d: got %0b want 0", i, bit_if.data_ready); end
            step(510);
            checks++; if (sym_strobe !== 1'b1) begin errors++; $display("FAIL ext_strobe bit%0d: got %0b want 1", i, sym_strobe); end
            step(1);
            r_exp = r_exp ^ b;
            checks++; if (bit_out !== b) begin errors++; $display("FAIL ext_bit bit%0d: got %0b want %0b", i, bit_out, b); end
            checks++; if (re !== r_exp) begin errors++; $display("FAIL ext_re bit%0d: got %0b want %0b", i, re, r_exp); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ext_underrun bit%0d: got %0b want 0", i, underrun); end
        end
        // Bit offered in the boundary clock with empty buffer goes straight out
        step(511);
        checks++; if (bit_if.data_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %0b want 1", bit_if.data_ready); end
        bit_if.data_in = 1'b1;
        bit_if.data_valid = 1'b1;
        step(1);
        bit_if.data_valid = 1'b0;
        r_exp = ~r_exp;
        checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL byp_bit: got %0b want 1", bit_out); end
        checks++; if (re !== r_exp) begin errors++; $display("FAIL byp_re: got %0b want %0b", re, r_exp); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL byp_underrun: got %0b want 0", underrun); end
        checks++; if (bit_if.data_ready !== 1'b1) begin errors++; $display("FAIL byp_ready_after: got %0b want 1", bit_if.data_ready); end
    endtask

    task automatic test_underrun;
        step(1);
        for (int i = 0; i < 3; i++) begin
            step(510);
            checks++; if (sym_strobe !== 1'b1) begin errors++; $display("FAIL und_strobe %0d: got %0b want 1", i, sym_strobe); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_early %0d: got %0b want 0", i, underrun); end
            step(1);
            checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_pulse %0d: got %0b want 1", i, underrun); end
            checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL und_bit %0d: got %0b want 0", i, bit_out); end
            checks++; if (re !== r_exp) begin errors++; $display("FAIL und_re %0d: got %0b want %0b", i, re, r_exp); end
            step(1);
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_width %0d: got %0b want 0", i, underrun); end
        end
    endtask

    task automatic test_stop;
        // At clock 1 of a DATA symbol; buffer a 1 that must be discarded
        bit_if.data_in = 1'b1;
        bit_if.data_valid = 1'b1;
        step(1);
        bit_if.data_valid = 1'b0;
        step(98);
        enable = 1'b0;
        step(411);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL stop_state_last: got %0d want 2", state); end
        checks++; if (sym_strobe !== 1'b1) begin errors++; $display("FAIL stop_strobe: got %0b want 1", sym_strobe); end
        step(1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_state: got %0d want 0", state); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL stop_bit: got %0b want 0", bit_out); end
        checks++; if (re !== r_exp) begin errors++; $display("FAIL stop_re: got %0b want %0b", re, r_exp); end
        checks++; if (bit_if.data_ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %0b want 0", bit_if.data_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL stop_underrun: got %0b want 0", underrun); end
        step(5);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_idle_state: got %0d want 0", state); end
        checks++; if (re !== r_exp) begin errors++; $display("FAIL stop_idle_re: got %0b want %0b", re, r_exp); end
        checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL stop_idle_strobe: got %0b want 0", sym_strobe); end
    endtask

`ifdef BDPSK_PRBS_EN
    task automatic test_prbs;
        logic [7:0] first8;
        logic       seq [128];
        int         ones;
        first8 = 8'b11111110;
        src_sel = 1'b1;
        enable = 1'b1;
        step(1);
        step(4096);
        // Eight preamble flips bring re back to its pre-entry value
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL prbs_state: got %0d want 2", state); end
        checks++; if (re !== (r_exp ^ 1'b1)) begin errors++; $display("FAIL prbs_first_re: got %0b want %0b", re, r_exp ^ 1'b1); end
        for (int i = 0; i < 128; i++) begin
            seq[i] = bit_out;
            if (i < 8) begin
                checks++; if (bit_out !== first8[7-i]) begin errors++; $display("FAIL prbs_bit%0d: got %0b want %0b", i, bit_out, first8[7-i]); end
            end
            step(512);
        end
        ones = 0;
        for (int i = 0; i < 127; i++) ones += int'(seq[i]);
        checks++; if (ones !== 64) begin errors++; $display("FAIL prbs_ones: got %0d want 64", ones); end
        checks++; if (seq[127] !== seq[0]) begin errors++; $display("FAIL prbs_period: got %0b want %0b", seq[127], seq[0]); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        r_exp = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        src_sel = 1'b0;
        bit_if.data_in = 1'b0;
        bit_if.data_valid = 1'b0;
        test_reset;
        test_preamble;
        test_external;
        test_underrun;
        test_stop;
`ifdef BDPSK_PRBS_EN
        test_prbs;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bdpsk_symbol_source.md
# bdpsk_symbol_source

Symbol source and differential encoder for the BDPSK transmitter; sits directly upstream of the sine-ROM address controller and drives its phase-select input `re`. Takes bits from an external one-entry handshake port or an internal PRBS7 generator, prepends a fixed preamble, and differentially encodes the bits. Updates `re` only on carrier-period boundaries, so phase flips coincide with sine-table wrap.

## Interface
Parameters:
- `SAMPLES_PER_CYCLE`, 128: clocks per carrier period (ROM depth downstream).
- `CYCLES_PER_SYMBOL`, 4: carrier periods per transmitted bit.
- `PREAMBLE_LEN`, 8: number of preamble symbols; each preamble bit is 1.

Ports:
- `clk` in 1: system clock, same clock as the address controller.
- `reset` in 1: asynchronous reset, active-high.
- `enable` in 1: start/continue transmission.
- `src_sel` in 1: 0 = external data, 1 = PRBS7. Effective only with `BDPSK_PRBS_EN`.
- `data_in` in 1: external bit.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: one-entry bit buffer is empty and the block is in DATA.
- `re` out 1: differentially encoded phase select; 0 = 0°, 1 = 180°.
- `bit_out` out 1: absolute bit of the current symbol.
- `sym_strobe` out 1: one-clock pulse on the last clock of each symbol.
- `underrun` out 1: one-clock pulse when a DATA boundary finds the buffer empty.
- `state` out 2: IDLE = 0, PREAMBLE = 1, DATA = 2.

## Operation
- Counters:
  - `samp_cnt` counts 0..SAMPLES_PER_CYCLE-1 and wraps.
  - `cyc_cnt` advances on each `samp_cnt` wrap and counts 0..CYCLES_PER_SYMBOL-1.
  - `pre_cnt` counts preamble symbols.
  - All counters are held at 0 in IDLE.
- A boundary occurs when `samp_cnt` = S-1 and `cyc_cnt` = C-1. `sym_strobe` is high in that clock.
- Symbol load (at the clock edge of a boundary, or on entry to PREAMBLE): `bit_out <= b`, `re <= re ^ b`.
- IDLE: `enable` sampled 1 moves to PREAMBLE and loads preamble bit 1 on the same edge.
- PREAMBLE: each boundary loads bit 1 and increments `pre_cnt`. The boundary that ends symbol PREAMBLE_LEN loads the first data bit and moves to DATA.
- DATA, external source:
  - `data_ready = (state == DATA) && !buf_full`.
  - A bit is accepted on an edge where `data_valid && data_ready`.
  - At each boundary the buffer bit is loaded and the buffer is emptied.
  - If the buffer is empty at a boundary: load `b` = 0 (phase unchanged) and pulse `underrun`.
  - If a bit is accepted in the same clock as a boundary that finds the buffer empty, that bit goes straight to the load (no underrun).
- DATA, PRBS source:
  - LFSR is 7 bits, polynomial x^7+x^6+1, seed 7'h7F.
  - Each boundary loads `b = lfsr[6]`, then shifts `lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}`.
  - The LFSR is re-seeded on entry to PREAMBLE.
- `enable` low in PREAMBLE or DATA:
  - The current symbol completes.
  - At the next boundary: go to IDLE, `bit_out <= 0`, `re` held, buffer cleared.
- Reset (any time, including mid-symbol): every output goes to 0 (`re`, `bit_out`, `data_ready`, `sym_strobe`, `underrun`, `state` = IDLE). Counters, buffer and LFSR return to reset/seed values.

## Timing
- Symbol length is exactly S×C clocks (512 at defaults).
- `re` and `bit_out` change only on the edge ending a `sym_strobe` clock, or on the IDLE→PREAMBLE edge. Both are registered, with zero combinational path from inputs.
- The first DATA symbol starts PREAMBLE_LEN×S×C clocks after the IDLE→PREAMBLE edge.
- `data_ready` is registered-state-derived. It rises the clock after a boundary empties the buffer.
- `underrun` is coincident with the load edge. It is registered and high for one clock.

## Configuration
- `BDPSK_PRBS_EN` defined: LFSR compiled in; `src_sel` selects the source.
- `BDPSK_PRBS_EN` undefined: no LFSR; `src_sel` is ignored and the external source is always used.

## Test plan
- Reset mid-PREAMBLE at `samp_cnt` = 37 -> all outputs 0 and `state` = 0 while `reset` is high. After release with `enable` = 1, the preamble restarts from symbol 0.
- `enable` = 1 from IDLE (defaults) -> `re` toggles 8 times at 512-clock spacing, starting on the entry edge. `re` = 0 and `state` = 2 after 4096 clocks.
- External bits 1,0,1,1 supplied when `data_ready` is high -> `re` = 1,1,0,1 and `bit_out` = 1,0,1,1 over successive 512-clock symbols. No `underrun`.
- `data_valid` held 0 in DATA -> `underrun` pulses once per boundary, `bit_out` = 0, `re` constant.
- `src_sel` = 1 with `BDPSK_PRBS_EN` -> first DATA bits are 1,1,1,1,1,1,1,0. Each 127-bit window contains 64 ones, and bit 128 equals bit 1.
- `enable` dropped at clock 100 of a DATA symbol -> symbol completes at clock 511, then `state` = 0, `bit_out` = 0, `re` unchanged, `data_ready` = 0.
